// File: rtl/key_speed_selector.sv
// rtl/key_speed_selector.sv - debounced KEY[3:1] control of blink mode, run flag and half-period
// Optional feature macro: KEY_AUTOREPEAT_EN (faster/slower strobes repeat while held).
module key_speed_selector #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int P_SLOW          = 90000000,
  parameter int P_MED           = 50000000,
  parameter int P_FAST          = 25000000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 25000000
`endif
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [3:1]  KEY,
  output logic [27:0] PERIOD,
  output logic [1:0]  MODE,
  output logic        RUN,
  output logic        PERIOD_CHG,
  output logic [2:0]  PRESS
);

  localparam logic [1:0] SLOW = 2'b00;
  localparam logic [1:0] MED  = 2'b01;
  localparam logic [1:0] FAST = 2'b10;

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]         r_sync1;
  logic [2:0]         r_sync2;
  logic [2:0]         r_stable;
  logic [2:0]         r_stable_d;
  logic [2:0][CW-1:0] r_db_cnt;
  logic [2:0]         r_press;
  logic [1:0]         r_mode;
  logic [1:0]         r_mode_d;
  logic               r_run;
  logic               r_chg;
  logic [2:0]         w_fall;
  logic [2:0]         w_strobe;
  logic [1:0]         w_mode_nxt;

  // Synchroniser and debouncer: stable only follows sync after an unbroken run of disagreement.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_stable   <= '1;
      r_stable_d <= '1;
      r_db_cnt   <= '0;
    end else begin
      r_sync1    <= KEY;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_fall = r_stable_d & ~r_stable;

`ifdef KEY_AUTOREPEAT_EN
  localparam int            RW      = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [1:0][RW-1:0] r_rep_cnt;
  logic [1:0]         w_repeat;

  // The first strobe restarts the interval so repeats land every REPEAT_CYCLES after it.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rep_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_stable[i] || w_fall[i] || (r_rep_cnt[i] == RP_LAST)) begin
          r_rep_cnt[i] <= '0;
        end else begin
          r_rep_cnt[i] <= r_rep_cnt[i] + RW'(1);
        end
      end
    end
  end

  assign w_repeat[0] = ~r_stable[0] & (r_rep_cnt[0] == RP_LAST);
  assign w_repeat[1] = ~r_stable[1] & (r_rep_cnt[1] == RP_LAST);
  assign w_strobe    = {w_fall[2], w_fall[1:0] | w_repeat};
`else
  assign w_strobe = w_fall;
`endif

  always_comb begin
    w_mode_nxt = r_mode;
    if (r_press[0] && !r_press[1]) begin
      if (r_mode == SLOW)     w_mode_nxt = MED;
      else if (r_mode == MED) w_mode_nxt = FAST;
    end else if (r_press[1] && !r_press[0]) begin
      if (r_mode == FAST)     w_mode_nxt = MED;
      else if (r_mode == MED) w_mode_nxt = SLOW;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_press  <= '0;
      r_mode   <= MED;
      r_mode_d <= MED;
      r_run    <= 1'b1;
      r_chg    <= 1'b0;
    end else begin
      r_press  <= w_strobe;
      r_mode   <= w_mode_nxt;
      r_mode_d <= r_mode;
      r_chg    <= (r_mode != r_mode_d);
      if (r_press[2]) r_run <= ~r_run;
    end
  end

  always_comb begin
    case (r_mode)
      SLOW:    PERIOD = 28'(P_SLOW);
      FAST:    PERIOD = 28'(P_FAST);
      default: PERIOD = 28'(P_MED);
    endcase
  end

  assign MODE       = r_mode;
  assign RUN        = r_run;
  assign PERIOD_CHG = r_chg;
  assign PRESS      = r_press;

endmodule

// File: tb/tb_key_speed_selector.sv
// tb/tb_key_speed_selector.sv - randomized and directed bench for key_speed_selector
module tb_key_speed_selector;

  localparam int DEB = 4;
  localparam int RPT = 16;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int PT[3] = '{9, 5, 3};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:1]  key   = 3'b111;
  logic [27:0] period;
  logic [1:0]  mode;
  logic        run;
  logic        period_chg;
  logic [2:0]  press;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_speed_selector #(
    .DEBOUNCE_CYCLES(DEB),
    .P_SLOW(9),
    .P_MED(5),
    .P_FAST(3)
`ifdef KEY_AUTOREPEAT_EN
    ,
    .REPEAT_CYCLES(RPT)
`endif
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .KEY(key),
    .PERIOD(period),
    .MODE(mode),
    .RUN(run),
    .PERIOD_CHG(period_chg),
    .PRESS(press)
  );

  // Reference model: a key's debounced level flips once the last DEB synchronised samples
  // (raw KEY delayed two edges) all disagree with it.
  bit h[3][DEB+2];
  bit m_stable[3];
  bit m_fell[3];
  bit m_press[3];
  bit m_hold[3];
  int m_last[3];
  int m_mode;
  bit m_run;
  bit m_chg;
  bit m_mchg;
  int edge_n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < DEB + 2; j++) h[k][j] = 1'b1;
      m_stable[k] = 1'b1;
      m_fell[k]   = 1'b0;
      m_press[k]  = 1'b0;
      m_hold[k]   = 1'b0;
      m_last[k]   = 0;
    end
    m_mode = 1;
    m_run  = 1'b1;
    m_chg  = 1'b0;
    m_mchg = 1'b0;
  endtask

  task automatic model_edge();
    int  nm;
    bit  rep;
    bit  all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    edge_n++;
    m_chg = m_mchg;
    nm = m_mode + (m_press[0] ? 1 : 0) - (m_press[1] ? 1 : 0);
    if (nm < 0) nm = 0;
    if (nm > 2) nm = 2;
    m_mchg = (nm != m_mode);
    m_mode = nm;
    if (m_press[2]) m_run = !m_run;
    for (int k = 0; k < 3; k++) begin
      if (m_stable[k]) m_hold[k] = 1'b0;
      rep = AR && (k < 2) && m_hold[k] && (edge_n - m_last[k] == RPT);
      m_press[k] = m_fell[k] || rep;
      if (m_press[k]) begin
        m_hold[k] = 1'b1;
        m_last[k] = edge_n;
      end
      for (int j = DEB + 1; j > 0; j--) h[k][j] = h[k][j-1];
      h[k][0] = key[k+1];
      all_diff = 1'b1;
      for (int j = 2; j <= DEB + 1; j++) if (h[k][j] == m_stable[k]) all_diff = 1'b0;
      m_fell[k] = 1'b0;
      if (all_diff) begin
        m_stable[k] = !m_stable[k];
        m_fell[k]   = !m_stable[k];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("mode", 32'(mode), 32'(m_mode));
    check_eq("period", 32'(period), 32'(PT[m_mode]));
    check_eq("run", 32'(run), 32'(m_run));
    check_eq("period_chg", 32'(period_chg), 32'(m_chg));
    check_eq("press", 32'(press), 32'({m_press[2], m_press[1], m_press[0]}));
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_mode", 32'(mode), 32'd1);
    check_eq("rst_period", 32'(period), 32'd5);
    check_eq("rst_run", 32'(run), 32'd1);
    check_eq("rst_press", 32'(press), 32'd0);
    check_eq("rst_chg", 32'(period_chg), 32'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  int press_at;
  int mode_at;
  int chg_at;
  int cnt_a;
  int cnt_b;
  int dur[3];
  bit all3;

  initial begin
    edge_n = 0;
    model_reset();
    do_reset();

    // clean press of the faster key
    step();
    step();
    key[1] = 1'b0;
    press_at = -1; mode_at = -1; chg_at = -1; cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (press[0]) begin cnt_a++; press_at = c; end
      if (mode == 2'b10 && mode_at < 0) mode_at = c;
      if (period_chg) begin cnt_b++; chg_at = c; end
    end
    check_eq("clean_press_cycle", 32'(press_at), 32'd7);
    check_eq("clean_press_count", 32'(cnt_a), 32'd1);
    check_eq("clean_mode_cycle", 32'(mode_at), 32'd8);
    check_eq("clean_period", 32'(period), 32'd3);
    check_eq("clean_chg_cycle", 32'(chg_at), 32'd9);
    check_eq("clean_chg_count", 32'(cnt_b), 32'd1);
    key = 3'b111;
    for (int c = 0; c < 10; c++) step();

    // bouncing slower key, then settled low
    do_reset();
    cnt_a = 0;
    for (int c = 0; c < 12; c++) begin
      key[2] = ((c / 2) % 2) != 0;
      step();
      if (press[1]) cnt_a++;
    end
    check_eq("bounce_no_press", 32'(cnt_a), 32'd0);
    key[2] = 1'b0;
    press_at = -1;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (press[1]) begin cnt_a++; press_at = c; end
    end
    check_eq("bounce_press_cycle", 32'(press_at), 32'd7);
    check_eq("bounce_press_count", 32'(cnt_a), 32'd1);
    check_eq("bounce_mode", 32'(mode), 32'd0);
    check_eq("bounce_period", 32'(period), 32'd9);
    key = 3'b111;
    for (int c = 0; c < 10; c++) step();

    // saturation at FAST
    do_reset();
    cnt_b = 0;
    for (int p = 0; p < 3; p++) begin
      key[1] = 1'b0;
      for (int c = 0; c < 12; c++) begin step(); if (period_chg) cnt_b++; end
      key[1] = 1'b1;
      for (int c = 0; c < 10; c++) begin step(); if (period_chg) cnt_b++; end
    end
    check_eq("sat_mode", 32'(mode), 32'd2);
    check_eq("sat_chg_count", 32'(cnt_b), 32'd1);

    // all three keys together
    all3 = 1'b0;
    key = 3'b000;
    for (int c = 0; c < 12; c++) begin
      step();
      if (press == 3'b111) all3 = 1'b1;
    end
    check_eq("simul_strobes", 32'(all3), 32'd1);
    check_eq("simul_mode", 32'(mode), 32'd2);
    check_eq("simul_run", 32'(run), 32'd0);
    key = 3'b111;
    for (int c = 0; c < 10; c++) step();

    // reset in the middle of a hold; key still held afterwards
    key[1] = 1'b0;
    for (int c = 0; c < 3; c++) step();
    do_reset();
    press_at = -1; cnt_a = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (press[0]) begin cnt_a++; if (press_at < 0) press_at = c; end
    end
    check_eq("held_reset_press_cycle", 32'(press_at), 32'd7);
    check_eq("held_reset_mode", 32'(mode), 32'd2);
    key = 3'b111;
    for (int c = 0; c < 10; c++) step();

    // randomized key activity against the model
    for (int k = 0; k < 3; k++) dur[k] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if (dur[k] == 0) begin
          key[k+1] = 1'($urandom_range(0, 1));
          dur[k]   = $urandom_range(1, 12);
        end else begin
          dur[k]--;
        end
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
